wb_interconnect_nxm: RTL and testbench
======================================

# wb_interconnect_nxm

Parametrised shared-bus Wishbone B4 interconnect connecting MASTERS masters to SLAVES slaves through one bus. It uses a registered round-robin arbiter and a base/mask address decoder. It adds two responses of its own: an error for unmapped addresses, and a watchdog error for slaves that never respond. It replaces the fixed 2×2 interconnect at the top of the Levenshtein SoC fabric.

## Interface
- MASTERS, 2: master count, 1..8
- SLAVES, 2: slave count, 1..8
- ADDR_WIDTH, 24: address width
- DATA_WIDTH, 8: data width, multiple of 8
- SEL_WIDTH, DATA_WIDTH/8: byte-select width
- SLAVE_BASE, 0: packed SLAVES×ADDR_WIDTH base addresses; slave s occupies slice s
- SLAVE_MASK, 0: packed SLAVES×ADDR_WIDTH decode masks; slave s matches when (adr & mask_s) == base_s
- TIMEOUT_CYCLES, 255: stall cycles before watchdog error; 0 disables the watchdog

Ports. Vectors are packed with master or slave index i in slice i.
- clk_i  in  1  clock, rising edge
- rst_ni  in  1  reset, asynchronous, active-low
- wbm_cyc_i, wbm_stb_i, wbm_we_i  in  MASTERS each  master cycle, strobe, write enable
- wbm_adr_i  in  MASTERS×ADDR_WIDTH  master addresses
- wbm_sel_i  in  MASTERS×SEL_WIDTH  master byte selects
- wbm_dat_i  in  MASTERS×DATA_WIDTH  master write data
- wbm_cti_i  in  MASTERS×3  master cycle type indicators
- wbm_bte_i  in  MASTERS×2  master burst type extensions
- wbm_ack_o, wbm_err_o, wbm_rty_o  out  MASTERS each  per-master responses
- wbm_dat_o  out  DATA_WIDTH  read data, broadcast to all masters
- wbs_cyc_o, wbs_stb_o  out  SLAVES each  per-slave cycle and strobe, decode-gated
- wbs_adr_o  out  ADDR_WIDTH  shared address
- wbs_we_o  out  1  shared write enable
- wbs_sel_o  out  SEL_WIDTH  shared byte select
- wbs_dat_o  out  DATA_WIDTH  shared write data
- wbs_cti_o  out  3  shared cycle type indicator
- wbs_bte_o  out  2  shared burst type extension
- wbs_ack_i, wbs_err_i, wbs_rty_i  in  SLAVES each  per-slave responses
- wbs_dat_i  in  SLAVES×DATA_WIDTH  per-slave read data

## Operation
- Arbiter registers:
  - `gnt_valid`
  - `gnt_idx` (one-hot, MASTERS bits)
  - `last_idx`, which resets to MASTERS-1 so master 0 wins first.
- Arbitration happens at a clock edge when `gnt_valid`=0 or the granted master's cyc is 0. The grant goes to the first requester with cyc=1, searching from `last_idx`+1 upward with wrap-around. If there is no requester, `gnt_valid` becomes 0. On every new grant, `last_idx` is set to the granted index.
- The grant is held for as long as the granted master keeps cyc=1. Bursts and RMW cycles are therefore atomic.
- Muxing: the shared slave-side signals come from the granted master. All of them are 0 when `gnt_valid`=0.
- Decode is combinational on the shared address. If several slaves match, the lowest index wins. `wbs_cyc_o[s]` = granted cyc & hit_s, and `wbs_stb_o[s]` = granted stb & hit_s.
- Responses (ack/err/rty) go to the granted master only. `wbm_dat_o` is the selected slave's `wbs_dat_i`, or 0 when there is no hit.
- Unmapped address: when stb=1 and no slave hits, the block returns its own error. `dec_err_q` is registered as 1 on the edge after such a stb, then cleared for one cycle. This gives one err pulse per classic cycle.
- Watchdog: a counter of width $clog2(TIMEOUT_CYCLES+1).
  - It increments while a hit slave is strobed and none of ack/err/rty is asserted.
  - It clears on any response or when stb=0.
  - When it reaches TIMEOUT_CYCLES, the block issues a one-cycle err to the granted master and the counter clears.
  - The slave's cyc/stb stay asserted until the master drops them.
- A master err from either source is the OR of the slave err, `dec_err_q` and the timeout err.

## Timing
- Reset state: all outputs 0, `gnt_valid`=0, counter 0, `dec_err_q`=0. Reset is asynchronous and applies mid-transfer with no handshake.
- Grant latency: cyc raised before edge N gives a grant at edge N. The slave sees cyc/stb during cycle N+1 (first cycle after the edge).
- Handover: a granted master drops cyc before edge N and another master is requesting → the new grant takes effect at edge N with no idle cycle.
- Slave responses pass through combinationally (zero added latency).
- Decode error: err is seen one cycle after stb.
- Timeout: err is seen TIMEOUT_CYCLES+1 cycles after the first unanswered stb.
- Simultaneous requests: round-robin order; no master can be starved.

## Structure
- Package `wb_pkg`:
  - CTI constants (CLASSIC=3'b000, CONST=3'b001, INCR=3'b010, EOB=3'b111)
  - BTE constants (LINEAR=2'b00, WRAP4/8/16)
  - a `wb_resp_t` struct {ack, err, rty}
- Sub-module `wb_rr_arbiter`, parametrised by MASTERS: inputs cyc vector, clk_i, rst_ni; outputs `gnt_valid` and `gnt_idx`.

## Test plan
- Reset: rst_ni=0 mid-burst → all outputs 0 asynchronously. After release, master 0 and master 1 request together → master 0 is granted first.
- Fairness: 3 masters hold cyc continuously, each doing one transfer and then dropping cyc for one cycle → grant order 0,1,2,0,1,2.
- Decode: SLAVE_BASE {0x000000, 0x800000}, masks 0x800000. Read 0x800010 → only `wbs_cyc_o[1]` asserted; data 0xA5 returned to the granted master only.
- Unmapped address: mask slave 1 as 0xFF0000 base 0x800000, access 0x900000 → one err pulse, no slave cyc asserted, `wbm_dat_o`=0.
- Timeout: TIMEOUT_CYCLES=4, slave never acks → err on the 5th cycle after stb. A second wait restarts the count.
- Burst hold: master 0 runs an INCR burst of 4 while master 1 requests → master 1 is granted only after master 0 drops cyc.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared Wishbone B4 definitions for the SoC fabric.
// Cycle-type / burst-type codes and the response bundle.
package wb_pkg;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_CONST   = 3'b001;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;

  localparam logic [1:0] BTE_LINEAR  = 2'b00;
  localparam logic [1:0] BTE_WRAP4   = 2'b01;
  localparam logic [1:0] BTE_WRAP8   = 2'b10;
  localparam logic [1:0] BTE_WRAP16  = 2'b11;

  typedef struct packed {
    logic ack;
    logic err;
    logic rty;
  } wb_resp_t;

endpackage

// File: rtl/wb_rr_arbiter.sv
// Registered round-robin arbiter; grant held while owner keeps cyc.
// Ports: clk_i, rst_ni, cyc[MASTERS] in; gnt_valid, gnt_idx (one-hot) out.
module wb_rr_arbiter
  import wb_pkg::*;
#(
  parameter int MASTERS = 2
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic [MASTERS-1:0] cyc,
  output logic               gnt_valid,
  output logic [MASTERS-1:0] gnt_idx
);

  localparam int IW = (MASTERS > 1) ? $clog2(MASTERS) : 1;

  logic [IW-1:0]      last_idx;
  logic [IW-1:0]      pick;
  logic [MASTERS-1:0] pick_oh;
  logic               found;
  logic               hold;

  // Two passes emulate a wrap-around search starting at last_idx+1.
  always_comb begin
    found   = 1'b0;
    pick    = '0;
    pick_oh = '0;
    for (int m = 0; m < MASTERS; m++) begin
      if (!found && cyc[m] && (m > int'(last_idx))) begin
        found      = 1'b1;
        pick       = IW'(m);
        pick_oh[m] = 1'b1;
      end
    end
    for (int m = 0; m < MASTERS; m++) begin
      if (!found && cyc[m] && (m <= int'(last_idx))) begin
        found      = 1'b1;
        pick       = IW'(m);
        pick_oh[m] = 1'b1;
      end
    end
  end

  assign hold = gnt_valid && (|(gnt_idx & cyc));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      gnt_valid <= 1'b0;
      gnt_idx   <= '0;
      last_idx  <= IW'(MASTERS - 1);
    end else if (!hold) begin
      gnt_valid <= found;
      gnt_idx   <= pick_oh;
      if (found) begin
        last_idx <= pick;
      end
    end
  end

endmodule

// File: rtl/wb_interconnect_nxm.sv
// Shared-bus N x M Wishbone B4 interconnect with RR arbitration,
// base/mask decode, unmapped-address error and stall watchdog.
// Ports: wbm_* master side (packed per master), wbs_* slave side.
module wb_interconnect_nxm
  import wb_pkg::*;
#(
  parameter int MASTERS        = 2,
  parameter int SLAVES         = 2,
  parameter int ADDR_WIDTH     = 24,
  parameter int DATA_WIDTH     = 8,
  parameter int SEL_WIDTH      = DATA_WIDTH / 8,
  parameter logic [SLAVES*ADDR_WIDTH-1:0] SLAVE_BASE = '0,
  parameter logic [SLAVES*ADDR_WIDTH-1:0] SLAVE_MASK = '0,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  logic [MASTERS-1:0]              wbm_cyc_i,
  input  logic [MASTERS-1:0]              wbm_stb_i,
  input  logic [MASTERS-1:0]              wbm_we_i,
  input  logic [MASTERS*ADDR_WIDTH-1:0]   wbm_adr_i,
  input  logic [MASTERS*SEL_WIDTH-1:0]    wbm_sel_i,
  input  logic [MASTERS*DATA_WIDTH-1:0]   wbm_dat_i,
  input  logic [MASTERS*3-1:0]            wbm_cti_i,
  input  logic [MASTERS*2-1:0]            wbm_bte_i,
  output logic [MASTERS-1:0]              wbm_ack_o,
  output logic [MASTERS-1:0]              wbm_err_o,
  output logic [MASTERS-1:0]              wbm_rty_o,
  output logic [DATA_WIDTH-1:0]           wbm_dat_o,
  output logic [SLAVES-1:0]               wbs_cyc_o,
  output logic [SLAVES-1:0]               wbs_stb_o,
  output logic [ADDR_WIDTH-1:0]           wbs_adr_o,
  output logic                            wbs_we_o,
  output logic [SEL_WIDTH-1:0]            wbs_sel_o,
  output logic [DATA_WIDTH-1:0]           wbs_dat_o,
  output logic [2:0]                      wbs_cti_o,
  output logic [1:0]                      wbs_bte_o,
  input  logic [SLAVES-1:0]               wbs_ack_i,
  input  logic [SLAVES-1:0]               wbs_err_i,
  input  logic [SLAVES-1:0]               wbs_rty_i,
  input  logic [SLAVES*DATA_WIDTH-1:0]    wbs_dat_i
);

  localparam int AW = ADDR_WIDTH;
  localparam int DW = DATA_WIDTH;
  localparam int SW = SEL_WIDTH;
  localparam bit WD_EN = (TIMEOUT_CYCLES > 0);
  localparam int CW = WD_EN ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] TMAX = CW'(TIMEOUT_CYCLES);

  logic               gnt_valid;
  logic [MASTERS-1:0] gnt_idx;

  logic          s_cyc;
  logic          s_stb;
  logic          s_we;
  logic [AW-1:0] s_adr;
  logic [SW-1:0] s_sel;
  logic [DW-1:0] s_dat;
  logic [2:0]    s_cti;
  logic [1:0]    s_bte;

  logic [SLAVES-1:0] hit;
  logic              hit_any;
  wb_resp_t          sresp;
  logic [DW-1:0]     rdata;

  logic          strobed;
  logic          dec_err_q;
  logic          to_err_q;
  logic [CW-1:0] wd_cnt;
  logic          m_err;
  logic          any_resp;

  wb_rr_arbiter #(
    .MASTERS(MASTERS)
  ) u_arb (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .cyc      (wbm_cyc_i),
    .gnt_valid(gnt_valid),
    .gnt_idx  (gnt_idx)
  );

  // AND-OR mux over the one-hot grant; idle bus reads as all zero.
  always_comb begin
    s_cyc = 1'b0;
    s_stb = 1'b0;
    s_we  = 1'b0;
    s_adr = '0;
    s_sel = '0;
    s_dat = '0;
    s_cti = '0;
    s_bte = '0;
    for (int m = 0; m < MASTERS; m++) begin
      if (gnt_valid && gnt_idx[m]) begin
        s_cyc |= wbm_cyc_i[m];
        s_stb |= wbm_stb_i[m];
        s_we  |= wbm_we_i[m];
        s_adr |= wbm_adr_i[m*AW +: AW];
        s_sel |= wbm_sel_i[m*SW +: SW];
        s_dat |= wbm_dat_i[m*DW +: DW];
        s_cti |= wbm_cti_i[m*3 +: 3];
        s_bte |= wbm_bte_i[m*2 +: 2];
      end
    end
  end

  assign wbs_adr_o = s_adr;
  assign wbs_we_o  = s_we;
  assign wbs_sel_o = s_sel;
  assign wbs_dat_o = s_dat;
  assign wbs_cti_o = s_cti;
  assign wbs_bte_o = s_bte;

  // Decode only inside an active cycle so an idle zero address
  // never selects a slave or leaks its read data.
  always_comb begin
    hit     = '0;
    hit_any = 1'b0;
    for (int s = 0; s < SLAVES; s++) begin
      if (!hit_any && s_cyc &&
          ((s_adr & SLAVE_MASK[s*AW +: AW]) ==
           SLAVE_BASE[s*AW +: AW])) begin
        hit[s]  = 1'b1;
        hit_any = 1'b1;
      end
    end
  end

  assign wbs_cyc_o = hit & {SLAVES{s_cyc}};
  assign wbs_stb_o = hit & {SLAVES{s_stb}};

  always_comb begin
    sresp = '0;
    rdata = '0;
    for (int s = 0; s < SLAVES; s++) begin
      if (hit[s]) begin
        sresp.ack |= wbs_ack_i[s];
        sresp.err |= wbs_err_i[s];
        sresp.rty |= wbs_rty_i[s];
        rdata     |= wbs_dat_i[s*DW +: DW];
      end
    end
  end

  assign strobed  = s_cyc & s_stb;
  assign m_err    = sresp.err | dec_err_q | to_err_q;
  assign any_resp = sresp.ack | sresp.rty | m_err;

  // dec_err_q self-clears so a held strobe sees one pulse
  // per attempt rather than a continuous error.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      dec_err_q <= 1'b0;
    end else begin
      dec_err_q <= strobed && !hit_any && !dec_err_q;
    end
  end

  // Own err pulse counts as a response, so the count restarts
  // from zero after each timeout.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wd_cnt   <= '0;
      to_err_q <= 1'b0;
    end else if (!WD_EN || !strobed || !hit_any || any_resp) begin
      wd_cnt   <= '0;
      to_err_q <= 1'b0;
    end else if (wd_cnt == TMAX) begin
      wd_cnt   <= '0;
      to_err_q <= 1'b1;
    end else begin
      wd_cnt   <= wd_cnt + 1'b1;
      to_err_q <= 1'b0;
    end
  end

  assign wbm_ack_o = gnt_idx & {MASTERS{gnt_valid & sresp.ack}};
  assign wbm_err_o = gnt_idx & {MASTERS{gnt_valid & m_err}};
  assign wbm_rty_o = gnt_idx & {MASTERS{gnt_valid & sresp.rty}};
  assign wbm_dat_o = rdata;

endmodule

// File: tb/tb_wb_interconnect_nxm.sv
// Directed bench for wb_interconnect_nxm: reset, grant order,
// decode, unmapped error, watchdog and burst atomicity.
module tb_wb_interconnect_nxm;
  import wb_pkg::*;

  localparam int M  = 3;
  localparam int S  = 2;
  localparam int AW = 24;
  localparam int DW = 8;
  localparam int SW = 1;
  localparam logic [S*AW-1:0] BASE = {24'h800000, 24'h000000};
  localparam logic [S*AW-1:0] MASK = {24'hFF0000, 24'h800000};

  logic clk = 1'b0;
  logic rst_n;
  logic [M-1:0]    cyc, stb, we;
  logic [M*AW-1:0] adr;
  logic [M*SW-1:0] sel;
  logic [M*DW-1:0] wdat;
  logic [M*3-1:0]  cti;
  logic [M*2-1:0]  bte;
  logic [M-1:0]    wbm_ack_o, wbm_err_o, wbm_rty_o;
  logic [DW-1:0]   wbm_dat_o;
  logic [S-1:0]    wbs_cyc_o, wbs_stb_o;
  logic [AW-1:0]   wbs_adr_o;
  logic            wbs_we_o;
  logic [SW-1:0]   wbs_sel_o;
  logic [DW-1:0]   wbs_dat_o;
  logic [2:0]      wbs_cti_o;
  logic [1:0]      wbs_bte_o;
  logic [S-1:0]    wbs_ack_i, wbs_err_i, wbs_rty_i;
  logic [S*DW-1:0] wbs_dat_i;
  logic [S-1:0]    ack_en;

  always #5 clk = ~clk;

  assign wbs_ack_i = wbs_cyc_o & wbs_stb_o & ack_en;
  assign wbs_err_i = '0;
  assign wbs_rty_i = '0;
  assign wbs_dat_i = {8'hA5, 8'h3C};

  wb_interconnect_nxm #(
    .MASTERS(M), .SLAVES(S), .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW), .SEL_WIDTH(SW),
    .SLAVE_BASE(BASE), .SLAVE_MASK(MASK),
    .TIMEOUT_CYCLES(4)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .wbm_cyc_i(cyc), .wbm_stb_i(stb), .wbm_we_i(we),
    .wbm_adr_i(adr), .wbm_sel_i(sel), .wbm_dat_i(wdat),
    .wbm_cti_i(cti), .wbm_bte_i(bte),
    .wbm_ack_o(wbm_ack_o), .wbm_err_o(wbm_err_o),
    .wbm_rty_o(wbm_rty_o), .wbm_dat_o(wbm_dat_o),
    .wbs_cyc_o(wbs_cyc_o), .wbs_stb_o(wbs_stb_o),
    .wbs_adr_o(wbs_adr_o), .wbs_we_o(wbs_we_o),
    .wbs_sel_o(wbs_sel_o), .wbs_dat_o(wbs_dat_o),
    .wbs_cti_o(wbs_cti_o), .wbs_bte_o(wbs_bte_o),
    .wbs_ack_i(wbs_ack_i), .wbs_err_i(wbs_err_i),
    .wbs_rty_i(wbs_rty_i), .wbs_dat_i(wbs_dat_i)
  );

  int n_chk = 0;
  int n_pass = 0;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int m, input logic c,
                       input logic [AW-1:0] a,
                       input logic [2:0] t);
    cyc[m] = c;
    stb[m] = c;
    adr[m*AW +: AW] = a;
    cti[m*3 +: 3] = t;
  endtask

  task automatic idle_all();
    cyc = '0;
    stb = '0;
  endtask

  int ord [6];
  int n_ord;
  logic [M-1:0] seen, drop;

  initial begin
    rst_n = 1'b0;
    cyc = '0; stb = '0; we = '0; adr = '0;
    sel = '1; wdat = '0; cti = '0; bte = '0;
    ack_en = 2'b00;

    repeat (2) step();
    check("rst cyc", 32'(wbs_cyc_o), 32'h0);
    check("rst ack", 32'(wbm_ack_o), 32'h0);
    check("rst dat", 32'(wbm_dat_o), 32'h0);
    check("rst adr", 32'(wbs_adr_o), 32'h0);
    rst_n = 1'b1;
    step();

    drive(0, 1'b1, 24'h000010, CTI_CLASSIC);
    drive(1, 1'b1, 24'h800020, CTI_CLASSIC);
    step();
    check("gnt cyc", 32'(wbs_cyc_o), 32'h1);
    check("gnt adr", 32'(wbs_adr_o), 32'h10);
    #3 rst_n = 1'b0;
    #1;
    check("arst cyc", 32'(wbs_cyc_o), 32'h0);
    check("arst stb", 32'(wbs_stb_o), 32'h0);
    check("arst adr", 32'(wbs_adr_o), 32'h0);
    #1 rst_n = 1'b1;
    step();
    check("post-rst cyc", 32'(wbs_cyc_o), 32'h1);
    check("post-rst adr", 32'(wbs_adr_o), 32'h10);
    idle_all();
    repeat (2) step();

    ack_en = 2'b11;
    drive(1, 1'b1, 24'h800010, CTI_CLASSIC);
    step();
    check("dec cyc", 32'(wbs_cyc_o), 32'h2);
    check("dec dat", 32'(wbm_dat_o), 32'hA5);
    check("dec ack", 32'(wbm_ack_o), 32'h2);
    idle_all();
    step();

    drive(2, 1'b1, 24'h900000, CTI_CLASSIC);
    step();
    check("unmap cyc", 32'(wbs_cyc_o), 32'h0);
    check("unmap dat", 32'(wbm_dat_o), 32'h0);
    check("unmap err0", 32'(wbm_err_o), 32'h0);
    step();
    check("unmap err1", 32'(wbm_err_o), 32'h4);
    check("unmap ack", 32'(wbm_ack_o), 32'h0);
    idle_all();
    step();
    check("unmap err2", 32'(wbm_err_o), 32'h0);

    ack_en = 2'b00;
    drive(0, 1'b1, 24'h000020, CTI_CLASSIC);
    for (int c = 0; c < 12; c++) begin
      step();
      check($sformatf("wdog c%0d", c), 32'(wbm_err_o),
            (c == 5 || c == 11) ? 32'h1 : 32'h0);
    end
    check("wdog stb held", 32'(wbs_stb_o), 32'h1);
    idle_all();
    ack_en = 2'b11;

    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    for (int m = 0; m < M; m++) drive(m, 1'b1, 24'h0, CTI_CLASSIC);
    n_ord = 0;
    seen = '0;
    drop = '0;
    for (int k = 0; k < 12; k++) begin
      step();
      for (int m = 0; m < M; m++) begin
        if (drop[m]) begin
          cyc[m] = 1'b1; stb[m] = 1'b1; drop[m] = 1'b0;
        end
        if (seen[m]) begin
          cyc[m] = 1'b0; stb[m] = 1'b0; drop[m] = 1'b1;
        end
      end
      #1;
      seen = wbm_ack_o;
      for (int m = 0; m < M; m++) begin
        if (wbm_ack_o[m] && n_ord < 6) begin
          ord[n_ord] = m;
          n_ord++;
        end
      end
    end
    check("rr count", 32'(n_ord), 32'd6);
    for (int i = 0; i < 6; i++)
      check($sformatf("rr ord%0d", i), 32'(ord[i]), 32'(i % 3));
    idle_all();
    repeat (2) step();

    drive(0, 1'b1, 24'h000000, CTI_INCR);
    drive(1, 1'b1, 24'h800000, CTI_CLASSIC);
    for (int b = 0; b < 4; b++) begin
      step();
      check($sformatf("burst ack%0d", b), 32'(wbm_ack_o), 32'h1);
      check($sformatf("burst adr%0d", b), 32'(wbs_adr_o), 32'(b));
      check($sformatf("burst cti%0d", b), 32'(wbs_cti_o),
            (b == 3) ? 32'(CTI_EOB) : 32'(CTI_INCR));
      if (b < 3)
        drive(0, 1'b1, 24'(b + 1),
              (b == 2) ? CTI_EOB : CTI_INCR);
      else
        drive(0, 1'b0, 24'h0, CTI_CLASSIC);
    end
    step();
    check("handover ack", 32'(wbm_ack_o), 32'h2);
    check("handover dat", 32'(wbm_dat_o), 32'hA5);
    idle_all();
    step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
